lbus_arbiter: RTL
=================

# lbus_arbiter

Round-robin arbiter that shares one single-outstanding local-bus target (the AXI3 bridge) among `NumM` local-bus masters. It sits between the masters and the bridge's `bus_*` port. It issues one request at a time as a single-cycle pulse, tracks the owner by ID, and routes the ready pulse and read data back to that owner only.

## Interface
- `NumM`, 4: number of masters, 2..8.
- `AddrW`, 8: address width.
- `DataW`, 32: data width.
- `IdW`, 2: bus ID width. Must satisfy `IdW >= $clog2(NumM)`.
- `StrbW`, `DataW/8`: byte-strobe width (constant).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `m_req`  in  NumM  per-master request; held until that master's `m_readyo`.
- `m_strb`  in  NumM*StrbW  per-master strobe, master i at `[i*StrbW +: StrbW]`. All-zero = read, otherwise write.
- `m_addr`  in  NumM*AddrW  per-master address, packed as above.
- `m_wdata`  in  NumM*DataW  per-master write data, packed as above.
- `m_readyo`  out  NumM  one-hot, one-cycle completion pulse to the owner.
- `m_rdatao`  out  DataW  read data; valid only with `m_readyo`.
- `s_reqo`  out  1  request pulse to the bridge.
- `s_ido`  out  IdW  owner index, zero-extended.
- `s_strbo`  out  StrbW  registered strobe.
- `s_addro`  out  AddrW  registered address.
- `s_wdatao`  out  DataW  registered write data.
- `s_ready`  in  1  bridge completion.
- `s_id`  in  IdW  bridge completion ID.
- `s_rdata`  in  DataW  bridge read data.
- `s_busy`  in  1  bridge holds a transaction.
- `err_o`  out  1  sticky protocol error.

## Operation
- State machine states: `ARB_IDLE`, `ARB_ISSUE`, `ARB_WAIT`.
- **ARB_IDLE**
  - If `|m_req && !s_busy`: pick the first requesting master at or after `r_ptr` (round-robin, wrapping modulo NumM).
  - Latch the winner's index into `r_owner`. Latch its strb/addr/wdata into the `s_*o` registers.
  - Set `r_ptr <= (winner+1) mod NumM`. Go to `ARB_ISSUE`.
  - If `s_busy` is high, no grant; stay in `ARB_IDLE`.
- **ARB_ISSUE**
  - `s_reqo` = 1 for exactly this cycle; it is never held longer.
  - If `s_ready && s_id==r_owner` (posted write, acked same cycle): pulse `m_readyo[r_owner]`, go to `ARB_IDLE`.
  - Otherwise go to `ARB_WAIT`.
- **ARB_WAIT**
  - On `s_ready && s_id==r_owner`: `m_readyo[r_owner]`=1, `m_rdatao`=`s_rdata` (combinational pass-through), go to `ARB_IDLE`.
  - On `s_ready` with mismatched `s_id`: set `err_o`, send no pulse, stay in `ARB_WAIT`.
- `s_ready` outside `ISSUE`/`WAIT` sets `err_o` and is otherwise ignored.
- `m_rdatao` is 0 whenever `m_readyo`==0.
- A master must drop `m_req` the cycle after its `m_readyo`. A request still high in `ARB_IDLE` is treated as a new request.
- A write is complete to the master at the bridge's ack. The next grant still waits for `!s_busy`, i.e. the write response.
- Reset (any state, including mid-transaction):
  - State → `ARB_IDLE`; `r_ptr`, `r_owner`, `err_o` → 0.
  - `s_reqo`, `s_strbo`, `s_addro`, `s_wdatao`, `s_ido` → 0; `m_readyo`, `m_rdatao` → 0.
  - An in-flight bridge transaction is abandoned. The bridge is reset by the same `reset`.

## Timing
- Arbitration latency: request sampled in cycle t (`ARB_IDLE`, `!s_busy`) → `s_reqo` in t+1.
- Write against an idle bridge: `m_readyo` in t+1. The next grant is possible once `s_busy` falls.
- Read with `arready`/`rvalid` both immediate: bridge ready in t+4 → `m_readyo` in t+4. The next grant is evaluated at t+5, `s_reqo` at t+6.
- Minimum spacing between two `s_reqo` pulses is 2 cycles.
- Fairness: with all masters requesting continuously, each master gets exactly one grant per NumM grants.

## Structure
- Package `lbus_pkg`: `arb_state_t` enum (`ARB_IDLE`=2'b00, `ARB_ISSUE`=2'b01, `ARB_WAIT`=2'b10). Encoding 2'b11 → `ARB_IDLE` via default.
- Sub-module `lbus_rr_pick`: combinational. Inputs `req[NumM]`, `ptr`. Outputs `grant_idx` and `grant_vld`. Implemented as a rotate / priority-encode / un-rotate.
- The top instantiates `lbus_rr_pick` and holds the FSM, the registered request slice and the return routing.

## Test plan
- Single read: master 2 reads addr 0x10, bridge model returns 0xDEADBEEF. Required: `s_reqo` pulse with `s_ido`=2; `m_readyo`=4'b0100 with `m_rdatao`=0xDEADBEEF; no other `m_readyo`.
- Round-robin: all 4 masters issue writes back-to-back, reset `r_ptr`=0. Required: grant order 0,1,2,3,0; each `s_reqo` only after `s_busy` low.
- Wrap/skip: `r_ptr`=3, only masters 1 and 3 requesting. Required: grant 3 then 1, `r_ptr`=2 afterwards.
- Busy hold-off: `s_busy`=1 for 10 cycles while master 0 requests. Required: no `s_reqo` during that window; `s_reqo` the cycle after the first `ARB_IDLE` cycle with `s_busy`=0.
- ID mismatch: in `ARB_WAIT` for owner 1, inject `s_ready` with `s_id`=3. Required: `err_o`=1 sticky, no `m_readyo`; a later `s_id`=1 completes normally.
- Reset mid-read: assert `reset` in `ARB_WAIT`. Required: all outputs 0 next cycle, `err_o`=0, and a fresh request to master 0 is granted first.

Source files
------------

// File: rtl/lbus_pkg.sv
// Shared types for the local-bus arbiter slice.
package lbus_pkg;

    // Arbiter FSM states; the unused 2'b11 encoding recovers to ARB_IDLE.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_ISSUE = 2'b01,
        ARB_WAIT  = 2'b10
    } arb_state_t;

endpackage

// File: rtl/lbus_rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping modulo NumM.
module lbus_rr_pick #(
    parameter int NumM = 4
) (
    input  logic [NumM-1:0]         req,
    input  logic [$clog2(NumM)-1:0] ptr,
    output logic [$clog2(NumM)-1:0] grant_idx,
    output logic                    grant_vld
);
    localparam int IdxW = $clog2(NumM);
    localparam logic [IdxW:0] NumMW = (IdxW+1)'(NumM);

    logic [2*NumM-1:0] dbl;
    logic [NumM-1:0]   rot;
    logic [IdxW-1:0]   off;
    logic [IdxW:0]     sum;

    // Rotate so ptr lands at bit 0, take the lowest set bit, then rotate the index back.
    always_comb begin
        dbl       = {req, req} >> ptr;
        rot       = dbl[NumM-1:0];
        grant_vld = |rot;
        off       = '0;
        for (int i = NumM - 1; i >= 0; i--) begin
            if (rot[i]) off = IdxW'(i);
        end
        sum = {1'b0, off} + {1'b0, ptr};
        if (sum >= NumMW) sum = sum - NumMW;
        grant_idx = sum[IdxW-1:0];
    end

endmodule

// File: rtl/lbus_arbiter.sv
// Round-robin arbiter sharing one single-outstanding bridge among NumM masters.
module lbus_arbiter
    import lbus_pkg::*;
#(
    parameter int NumM  = 4,
    parameter int AddrW = 8,
    parameter int DataW = 32,
    parameter int IdW   = 2,
    localparam int StrbW = DataW / 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NumM-1:0]        m_req,
    input  logic [NumM*StrbW-1:0]  m_strb,
    input  logic [NumM*AddrW-1:0]  m_addr,
    input  logic [NumM*DataW-1:0]  m_wdata,
    output logic [NumM-1:0]        m_readyo,
    output logic [DataW-1:0]       m_rdatao,
    output logic                   s_reqo,
    output logic [IdW-1:0]         s_ido,
    output logic [StrbW-1:0]       s_strbo,
    output logic [AddrW-1:0]       s_addro,
    output logic [DataW-1:0]       s_wdatao,
    input  logic                   s_ready,
    input  logic [IdW-1:0]         s_id,
    input  logic [DataW-1:0]       s_rdata,
    input  logic                   s_busy,
    output logic                   err_o
);
    localparam int IdxW = $clog2(NumM);

    arb_state_t      state, state_nxt;
    logic [IdxW-1:0] r_ptr, r_owner, ptr_nxt, pick_idx;
    logic            pick_vld, grant, done, err_set, id_match;

    logic [StrbW-1:0] strb_arr  [NumM];
    logic [AddrW-1:0] addr_arr  [NumM];
    logic [DataW-1:0] wdata_arr [NumM];

    for (genvar gi = 0; gi < NumM; gi++) begin : g_unpack
        assign strb_arr[gi]  = m_strb[gi*StrbW +: StrbW];
        assign addr_arr[gi]  = m_addr[gi*AddrW +: AddrW];
        assign wdata_arr[gi] = m_wdata[gi*DataW +: DataW];
    end

    lbus_rr_pick #(.NumM(NumM)) u_pick (
        .req       (m_req),
        .ptr       (r_ptr),
        .grant_idx (pick_idx),
        .grant_vld (pick_vld)
    );

    assign id_match = s_ready && (s_id == IdW'(r_owner));
    assign s_reqo   = (state == ARB_ISSUE);
    assign s_ido    = IdW'(r_owner);

    // Pointer moves one past the winner so the winner goes to the back of the line.
    always_comb begin
        ptr_nxt = (pick_idx == IdxW'(NumM - 1)) ? '0 : pick_idx + IdxW'(1);
    end

    // Next-state, grant and completion decode.
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        done      = 1'b0;
        err_set   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (s_ready) err_set = 1'b1;
                if (pick_vld && !s_busy) begin
                    grant     = 1'b1;
                    state_nxt = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                // A posted write may be acked in the same cycle as the request.
                if (id_match) begin
                    done      = 1'b1;
                    state_nxt = ARB_IDLE;
                end else begin
                    if (s_ready) err_set = 1'b1;
                    state_nxt = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (id_match) begin
                    done      = 1'b1;
                    state_nxt = ARB_IDLE;
                end else if (s_ready) begin
                    err_set = 1'b1;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Return path: completion pulse and read data go to the owner only.
    always_comb begin
        m_readyo = '0;
        for (int i = 0; i < NumM; i++) begin
            m_readyo[i] = done && (r_owner == IdxW'(i));
        end
        m_rdatao = done ? s_rdata : '0;
    end

    // State, pointer, owner, latched request slice and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB_IDLE;
            r_ptr    <= '0;
            r_owner  <= '0;
            err_o    <= 1'b0;
            s_strbo  <= '0;
            s_addro  <= '0;
            s_wdatao <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                r_owner  <= pick_idx;
                r_ptr    <= ptr_nxt;
                s_strbo  <= strb_arr[pick_idx];
                s_addro  <= addr_arr[pick_idx];
                s_wdatao <= wdata_arr[pick_idx];
            end
            if (err_set) err_o <= 1'b1;
        end
    end

endmodule
